// File: rtl/mc_control_fsm_if.sv
// Shared memory port between the multicycle control unit and memory.
// The controller owns the request side; memory answers with MemReady.
interface mc_control_fsm_if;
    logic       MemReq;
    logic       MemW;
    logic       MemReady;
    logic       AdrSrc;
    logic [2:0] MemSize;

    modport master (
        output MemReq,
        output MemW,
        output AdrSrc,
        output MemSize,
        input  MemReady
    );

    modport slave (
        input  MemReq,
        input  MemW,
        input  AdrSrc,
        input  MemSize,
        output MemReady
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle ARM control unit: sequences fetch/decode/execute/memory/writeback
// over a shared req/ready memory port, with a memory timeout and a sticky fault.
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter bit SUPPORT_BL  = 1'b1,
    parameter int ALUC_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  mem,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic [7:0]        ShInstr,
    input  logic              CondEx,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegW,
    output logic              LinkW,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [3:0]        FlagW,
    output logic [2:0]        ShiftOp,
    output logic              RegShift,
    output logic              Fault
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
    } state_t;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(4'h4);

    state_t           state, state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             cond_q;
    logic             mem_wait;
    logic             timeout;
    logic             alu_wb;
    logic [11:4]      ins;

    // Shift-field bits are addressed by their instruction bit numbers.
    assign ins      = ShInstr;
    assign mem_wait = mem.MemReq & ~mem.MemReady;
    assign timeout  = (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign RegShift = ins[4] & ~ins[7];
    assign ImmSrc   = (Op == 2'b11) ? 2'b00 : Op;
    assign RegSrc   = {Op == 2'b01, Op == 2'b10};
    assign Fault    = (state == S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cond_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state)
                wait_cnt <= '0;
            else if (mem_wait)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == S_DECODE)
                cond_q <= CondEx;
        end
    end

    always_comb begin
        state_next  = state;
        mem.MemReq  = 1'b0;
        mem.MemW    = 1'b0;
        mem.AdrSrc  = 1'b0;
        mem.MemSize = 3'b010;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        RegW        = 1'b0;
        LinkW       = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUControl  = ALU_ADD;
        FlagW       = 4'b0000;
        ShiftOp     = 3'd5;
        alu_wb      = 1'b0;

        case (state)
            S_FETCH: begin
                mem.MemReq = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                if (mem.MemReady) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!CondEx)
                    state_next = S_FETCH;
                else begin
                    case (Op)
                        2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
                        2'b01:   state_next = S_MEMADR;
                        2'b10:   state_next = S_BRANCH;
                        default: state_next = S_FAULT;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = ALUC_W'(Funct[4:1]);
                case (Funct[4:1])
                    4'hA, 4'hB: FlagW = {4{cond_q}};
                    4'h8, 4'h9: FlagW = {{3{cond_q}}, 1'b0};
                    default:    FlagW = {{3{cond_q & Funct[0]}}, 1'b0};
                endcase
                if (state == S_EXECI)
                    ShiftOp = 3'd3;
                else if (ins[11:7] == 5'd0 && !ins[4] && ins[6:5] == 2'b11)
                    ShiftOp = 3'd4;
                else
                    ShiftOp = {1'b0, ins[6:5]};
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                alu_wb     = cond_q & (Funct[4:3] != 2'b10);
                RegW       = alu_wb;
                PCWrite    = alu_wb & (Rd == 4'hF);
                state_next = S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                state_next = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                mem.MemReq  = 1'b1;
                mem.AdrSrc  = 1'b1;
                mem.MemSize = {1'b0, Funct[2] ? 2'b00 : 2'b10};
                mem.MemW    = (state == S_MEMWR) & cond_q;
                if (mem.MemReady)
                    state_next = (state == S_MEMRD) ? S_MEMWB : S_FETCH;
                else if (timeout)
                    state_next = S_FAULT;
            end
            S_MEMWB: begin
                RegW       = cond_q;
                ResultSrc  = 2'b01;
                PCWrite    = cond_q & (Rd == 4'hF);
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                PCWrite    = cond_q;
                LinkW      = cond_q & Funct[4] & SUPPORT_BL;
                state_next = S_FETCH;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FAULT;
        endcase

        // Reset cycle must never leak a write, even mid-instruction.
        if (reset) begin
            mem.MemReq = 1'b0;
            mem.MemW   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegW       = 1'b0;
            LinkW      = 1'b0;
            FlagW      = 4'b0000;
        end
    end
endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomised scoreboard bench for mc_control_fsm: the driver predicts timestamped
// write events per instruction, a negedge monitor compares what the DUT emits.
module tb_mc_control_fsm;
    localparam int TO = 16;
    localparam logic [3:0] ADD_OP = 4'h4;
    localparam logic [1:0] SZ_BYTE = 2'd0, SZ_WORD = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic [7:0] ShInstr = '0;
    logic       CondEx = 1'b0;
    logic       IRWrite, PCWrite, RegW, LinkW, ALUSrcA, RegShift, Fault;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [3:0] ALUControl, FlagW;
    logic [2:0] ShiftOp;

    mc_control_fsm_if mif ();

    mc_control_fsm #(.MEM_TIMEOUT(TO), .SUPPORT_BL(1'b1), .ALUC_W(4)) dut (
        .clk(clk), .reset(reset), .mem(mif),
        .Op(Op), .Funct(Funct), .Rd(Rd), .ShInstr(ShInstr), .CondEx(CondEx),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegW(RegW), .LinkW(LinkW),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .FlagW(FlagW), .ShiftOp(ShiftOp), .RegShift(RegShift), .Fault(Fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic irw, pcw, regw, linkw, acc, memw, adrsrc, rs;
        logic [3:0] flagw, aluc;
        logic [2:0] msize, shop;
        logic [1:0] rsrc;
        logic chka, chks;
    } ev_t;

    ev_t expq[$];
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t blank(input int unsigned c);
        ev_t e;
        e = '{default: '0};
        e.cyc = c;
        return e;
    endfunction

    // Monitor: any cycle that writes state or completes a memory access is an event.
    always @(negedge clk) begin
        ev_t a, e;
        logic acc;
        acc = mif.MemReq & mif.MemReady;
        if ((IRWrite | PCWrite | RegW | LinkW | (|FlagW) | acc) === 1'b1) begin
            a = blank(cyc);
            a.irw = IRWrite; a.pcw = PCWrite; a.regw = RegW; a.linkw = LinkW;
            a.flagw = FlagW; a.acc = acc; a.memw = mif.MemW & acc;
            a.adrsrc = mif.AdrSrc & acc;
            a.msize = (acc & mif.AdrSrc) ? mif.MemSize : 3'd0;
            a.rsrc = (PCWrite | RegW) ? ResultSrc : 2'd0;
            a.aluc = ALUControl; a.shop = ShiftOp; a.rs = RegShift;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d got irw=%b pcw=%b regw=%b linkw=%b flagw=%b acc=%b required none",
                         cyc, a.irw, a.pcw, a.regw, a.linkw, a.flagw, a.acc);
            end else begin
                e = expq.pop_front();
                if (a.cyc != e.cyc || a.irw !== e.irw || a.pcw !== e.pcw || a.regw !== e.regw ||
                    a.linkw !== e.linkw || a.flagw !== e.flagw || a.acc !== e.acc ||
                    a.memw !== e.memw || a.adrsrc !== e.adrsrc || a.msize !== e.msize ||
                    a.rsrc !== e.rsrc || (e.chka && a.aluc !== e.aluc) ||
                    (e.chks && (a.shop !== e.shop || a.rs !== e.rs))) begin
                    bad++;
                    $display("FAIL event got cyc=%0d irw=%b pcw=%b regw=%b linkw=%b flagw=%b acc=%b memw=%b adr=%b msz=%0d rsrc=%0d aluc=%h sh=%0d rs=%b | required cyc=%0d irw=%b pcw=%b regw=%b linkw=%b flagw=%b acc=%b memw=%b adr=%b msz=%0d rsrc=%0d aluc=%h sh=%0d rs=%b",
                             a.cyc, a.irw, a.pcw, a.regw, a.linkw, a.flagw, a.acc, a.memw, a.adrsrc, a.msize, a.rsrc, a.aluc, a.shop, a.rs,
                             e.cyc, e.irw, e.pcw, e.regw, e.linkw, e.flagw, e.acc, e.memw, e.adrsrc, e.msize, e.rsrc, e.aluc, e.shop, e.rs);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] model_flags(input logic [5:0] f);
        case (f[4:1])
            4'hA, 4'hB: return 4'b1111;     // CMP, CMN
            4'h8, 4'h9: return 4'b1110;     // TST, TEQ
            default:    return f[0] ? 4'b1110 : 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] model_shift(input logic [5:0] f, input logic [7:0] sh);
        logic [11:0] w;
        w = {sh, 4'b0000};
        if (f[5]) return 3'd3;
        if (w[11:7] == 5'd0 && !w[4] && w[6:5] == 2'b11) return 3'd4;
        return {1'b0, w[6:5]};
    endfunction

    // Predict the instruction's events, then drive it cycle by cycle.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
                             input logic [7:0] sh, input logic c,
                             input int unsigned fw, input int unsigned dw);
        int unsigned t0, len;
        int ds;
        logic [11:0] w;
        ev_t e;
        t0 = cyc;
        ds = -1;
        w = {sh, 4'b0000};
        e = blank(t0 + fw);
        e.irw = 1; e.pcw = 1; e.acc = 1; e.rsrc = 2'd2; e.chka = 1; e.aluc = ADD_OP;
        expq.push_back(e);
        len = fw + 2;
        if (c) begin
            case (op)
                2'b00: begin
                    if (model_flags(f) != 0) begin
                        e = blank(t0 + fw + 2);
                        e.flagw = model_flags(f); e.chka = 1; e.aluc = f[4:1];
                        e.chks = 1; e.shop = model_shift(f, sh); e.rs = w[4] & ~w[7];
                        expq.push_back(e);
                    end
                    if (f[4:3] != 2'b10) begin
                        e = blank(t0 + fw + 3);
                        e.regw = 1; e.pcw = (rd == 4'd15);
                        expq.push_back(e);
                    end
                    len = fw + 4;
                end
                2'b01: begin
                    ds = int'(fw) + 3;
                    e = blank(t0 + ds + dw);
                    e.acc = 1; e.adrsrc = 1; e.memw = ~f[0];
                    e.msize = {1'b0, f[2] ? SZ_BYTE : SZ_WORD};
                    expq.push_back(e);
                    len = ds + dw + 1;
                    if (f[0]) begin
                        e = blank(t0 + len);
                        e.regw = 1; e.rsrc = 2'd1; e.pcw = (rd == 4'd15);
                        expq.push_back(e);
                        len++;
                    end
                end
                2'b10: begin
                    e = blank(t0 + fw + 2);
                    e.pcw = 1; e.linkw = f[4]; e.rsrc = 2'd2; e.chka = 1; e.aluc = ADD_OP;
                    expq.push_back(e);
                    len = fw + 3;
                end
                default: len = fw + 2;
            endcase
        end
        Op = op; Funct = f; Rd = rd; ShInstr = sh; CondEx = c;
        for (int unsigned i = 0; i < len; i++) begin
            if (i <= fw)
                mif.MemReady = (i == fw);
            else if (ds >= 0 && int'(i) >= ds && i <= ds + dw)
                mif.MemReady = (int'(i) == ds + int'(dw));
            else
                mif.MemReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mif.MemReady = 1'b1;
        @(posedge clk); #1;
        chk("reset_cycle_memreq", mif.MemReq, 0);
        chk("reset_cycle_strobes", {IRWrite, PCWrite, RegW, LinkW, mif.MemW, FlagW}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mif.MemReady = 1'b0;
        #1;
        chk("post_reset_fetch_memreq", mif.MemReq, 1);
        chk("post_reset_fault", Fault, 0);
    endtask

    initial begin
        mif.MemReady = 1'b0;
        do_reset();

        run_instr(2'b00, 6'b001000, 4'd1, 8'h00, 1'b1, 0, 0);  // ADD r1,r2,r3
        run_instr(2'b00, 6'b010101, 4'd0, 8'h00, 1'b1, 0, 0);  // CMP
        run_instr(2'b01, 6'b000101, 4'd2, 8'h00, 1'b1, 0, 3);  // LDRB, 3 wait cycles
        run_instr(2'b10, 6'b010000, 4'd0, 8'h00, 1'b0, 0, 0);  // BL, condition fails
        run_instr(2'b10, 6'b010000, 4'd0, 8'h00, 1'b1, 1, 0);  // BL taken
        run_instr(2'b00, 6'b001000, 4'd15, 8'h06, 1'b1, 2, 0); // ADD pc, RRX
        run_instr(2'b01, 6'b000001, 4'd15, 8'h00, 1'b1, TO - 1, TO - 1); // ready on last allowed cycle
        run_instr(2'b01, 6'b000000, 4'd3, 8'h00, 1'b1, 0, 2);  // STR word

        // Unimplemented op faults after DECODE.
        run_instr(2'b11, 6'b000000, 4'd0, 8'h00, 1'b1, 0, 0);
        #1;
        chk("op11_fault", Fault, 1);
        do_reset();

        // Fetch timeout.
        Op = 2'b00; Funct = 6'b001000; CondEx = 1'b1;
        mif.MemReady = 1'b0;
        for (int unsigned i = 0; i < TO; i++) begin
            if (i == TO - 1) begin
                chk("timeout_last_wait_fault", Fault, 0);
                chk("timeout_last_wait_memreq", mif.MemReq, 1);
            end
            @(posedge clk); #1;
        end
        chk("timeout_fault", Fault, 1);
        chk("timeout_memreq", mif.MemReq, 0);
        for (int i = 0; i < 5; i++) begin
            mif.MemReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("fault_sticky", Fault, 1);
        do_reset();

        // Reset in MEMWR while memory is ready.
        begin
            ev_t e;
            e = blank(cyc);
            e.irw = 1; e.pcw = 1; e.acc = 1; e.rsrc = 2'd2; e.chka = 1; e.aluc = ADD_OP;
            expq.push_back(e);
            Op = 2'b01; Funct = 6'b000000; Rd = 4'd4; CondEx = 1'b1;
            for (int i = 0; i < 3; i++) begin
                mif.MemReady = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            chk("memwr_before_reset_memw", mif.MemW, 1);
            reset = 1'b1;
            mif.MemReady = 1'b1;
            #1;
            chk("reset_in_memwr_memw", mif.MemW, 0);
            chk("reset_in_memwr_memreq", mif.MemReq, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            mif.MemReady = 1'b0;
            #1;
            chk("after_memwr_reset_fetch", mif.MemReq, 1);
            chk("after_memwr_reset_adrsrc", mif.AdrSrc, 0);
        end

        for (int n = 0; n < 150; n++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [7:0] sh;
            int unsigned fw, dw;
            op = 2'($urandom_range(0, 2));
            f  = 6'($urandom);
            sh = ($urandom_range(0, 3) == 0) ? {5'd0, 3'($urandom)} : 8'($urandom);
            fw = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
            dw = ($urandom_range(0, 9) == 0) ? TO - 1 : $urandom_range(0, 3);
            run_instr(op, f, 4'($urandom), sh, ($urandom_range(0, 4) != 0), fw, dw);
        end

        @(posedge clk); #1;
        chk("scoreboard_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
